// File: rtl/writeback_arbiter.sv
// Writeback arbiter: buffers one completed result per functional unit
// (ALU/misc, memory, multiplier), selects one buffered result per cycle by
// round-robin, writes it to the register file and clears its scoreboard row.
module writeback_arbiter #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   am_wb_valid,
  input  logic [4:0]             am_wb_regdest,
  input  logic [31:0]            am_wb_data,
  input  logic                   am_wb_writereg,
  output logic                   wb_am_ready,

  input  logic                   mem_wb_valid,
  input  logic [4:0]             mem_wb_regdest,
  input  logic [31:0]            mem_wb_data,
  input  logic                   mem_wb_writereg,
  output logic                   wb_mem_ready,

  input  logic                   mul_wb_valid,
  input  logic [4:0]             mul_wb_regdest,
  input  logic [31:0]            mul_wb_data,
  input  logic                   mul_wb_writereg,
  output logic                   wb_mul_ready,

  output logic [4:0]             wb_reg_writeaddr,
  output logic [31:0]            wb_reg_writedata,
  output logic                   wb_reg_writeenable,
  output logic [4:0]             wb_sb_clearaddr,
  output logic [1:0]             wb_sb_clearunit,
  output logic                   wb_sb_clear,
  output logic [COUNT_WIDTH-1:0] wb_retired
);

  // Unit codes double as slot indices and as the scoreboard clear-unit code.
  typedef enum logic [1:0] {
    UNIT_AM  = 2'b00,
    UNIT_MEM = 2'b01,
    UNIT_MUL = 2'b10
  } unit_e;

  typedef struct packed {
    logic [4:0]  regdest;
    logic [31:0] data;
    logic        writereg;
  } result_t;

  // Round-robin successor in the fixed order AM -> Mem -> Mult -> AM.
  function automatic unit_e next_unit(unit_e u);
    case (u)
      UNIT_AM:  return UNIT_MEM;
      UNIT_MEM: return UNIT_MUL;
      default:  return UNIT_AM;
    endcase
  endfunction

  logic [2:0] in_valid;
  result_t    in_result [3];

  result_t    slot_q [3];
  logic [2:0] slot_full_q;
  unit_e      last_q;

  logic       grant_valid;
  unit_e      grant_unit;
  unit_e      cand;
  logic [2:0] grant_oh;
  result_t    grant_res;

  assign in_valid     = {mul_wb_valid, mem_wb_valid, am_wb_valid};
  assign in_result[0] = '{regdest: am_wb_regdest,  data: am_wb_data,  writereg: am_wb_writereg};
  assign in_result[1] = '{regdest: mem_wb_regdest, data: mem_wb_data, writereg: mem_wb_writereg};
  assign in_result[2] = '{regdest: mul_wb_regdest, data: mul_wb_data, writereg: mul_wb_writereg};

  // Ready depends only on registered slot state, never on the incoming valid.
  assign wb_am_ready  = ~slot_full_q[0];
  assign wb_mem_ready = ~slot_full_q[1];
  assign wb_mul_ready = ~slot_full_q[2];

  // Round-robin pick among full slots, starting just after the last winner.
  always_comb begin
    // NOTE: every variable gets a default before any condition so no latch is inferred.
    grant_valid = 1'b0;
    grant_unit  = UNIT_AM;
    cand        = next_unit(last_q);
    for (int k = 0; k < 3; k++) begin
      if (!grant_valid && slot_full_q[cand]) begin
        grant_valid = 1'b1;
        grant_unit  = cand;
      end
      cand = next_unit(cand);
    end
    grant_oh  = grant_valid ? (3'b001 << grant_unit) : 3'b000;
    grant_res = slot_q[grant_unit];
  end

  // Slot payload capture on valid & ready.
  // NOTE: payload registers carry no reset; the full flags alone decide whether contents are meaningful.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (in_valid[i] && !slot_full_q[i]) begin
        slot_q[i] <= in_result[i];
      end
    end
  end

  // Slot occupancy: the winner empties, an empty slot fills on a handshake.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      slot_full_q <= 3'b000;
    end else begin
      slot_full_q <= (slot_full_q & ~grant_oh) | (in_valid & ~slot_full_q);
    end
  end

  // Output registers, retire counter and round-robin pointer, loaded on a grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wb_reg_writeaddr   <= 5'd0;
      wb_reg_writedata   <= 32'd0;
      wb_reg_writeenable <= 1'b0;
      wb_sb_clearaddr    <= 5'd0;
      wb_sb_clearunit    <= 2'b00;
      wb_sb_clear        <= 1'b0;
      wb_retired         <= '0;
      last_q             <= UNIT_MUL;
    end else begin
      wb_reg_writeenable <= 1'b0;
      wb_sb_clear        <= 1'b0;
      if (grant_valid) begin
        wb_reg_writeenable <= grant_res.writereg && (grant_res.regdest != 5'd0);
        wb_reg_writeaddr   <= grant_res.regdest;
        wb_reg_writedata   <= grant_res.data;
        wb_sb_clear        <= grant_res.writereg;
        wb_sb_clearaddr    <= grant_res.regdest;
        wb_sb_clearunit    <= grant_unit;
        wb_retired         <= wb_retired + COUNT_WIDTH'(1);
        last_q             <= grant_unit;
      end
    end
  end

endmodule
